// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port, the decode handshake, the redirect
// path and the fault flag of the fetch stage.
interface fetch_unit_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        fault_o;

  // Fetch-unit side
  modport master (
    output imem_en, imem_addr, instr_o, pc_o, valid_o, fault_o,
    input  imem_rdata, redirect_i, target_i, ready_i
  );

  // Environment side: memory, execute redirect path and decode
  modport slave (
    input  imem_en, imem_addr, instr_o, pc_o, valid_o, fault_o,
    output imem_rdata, redirect_i, target_i, ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, drives a 1-cycle-latency
// instruction memory and hands instruction+PC to decode through a 2-deep
// buffer (output register plus skid register). Redirects flush the buffer
// and any in-flight read; a misaligned redirect target halts with a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        fault_q, fault_d;

  logic        issue_s;
  logic        consume_s;
  logic [1:0]  occupancy_s;

  // Memory request is combinational so a redirect suppresses it in the same cycle
  assign bus.imem_en   = issue_s;
  assign bus.imem_addr = pc_fetch_q;
  assign bus.instr_o   = out_instr_q;
  assign bus.pc_o      = out_pc_q;
  assign bus.valid_o   = out_valid_q;
  assign bus.fault_o   = fault_q;

  // A transfer to decode happens on valid && ready
  assign consume_s = out_valid_q && bus.ready_i;

  // Slots that will still be occupied after this edge; an output being
  // consumed frees its slot, so only a stalled output counts
  assign occupancy_s = {1'b0, (out_valid_q && !bus.ready_i)}
                     + {1'b0, skid_valid_q}
                     + {1'b0, inflight_q};

  // Next-state, fetch issue and buffer management
  always_comb begin
    state_d       = state_q;
    pc_fetch_d    = pc_fetch_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    fault_d       = fault_q;
    issue_s       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        inflight_d = 1'b0;
      end

      ST_RUN: begin
        if (bus.redirect_i) begin
          // Redirect wins over issue, capture and handshake; the in-flight
          // response belongs to the old path and is dropped
          out_valid_d  = 1'b0;
          out_instr_d  = NOP_INSTR;
          skid_valid_d = 1'b0;
          inflight_d   = 1'b0;
          pc_fetch_d   = bus.target_i;
          if (bus.target_i[1:0] != 2'b00) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          // Issue only if the response is guaranteed a free slot
          if (occupancy_s < 2'd2) begin
            issue_s       = 1'b1;
            pc_fetch_d    = pc_fetch_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_fetch_q;
          end else begin
            inflight_d = 1'b0;
          end

          // Older skid entry always advances before a new response lands
          if (consume_s) begin
            if (skid_valid_q) begin
              out_valid_d = 1'b1;
              out_instr_d = skid_instr_q;
              out_pc_d    = skid_pc_q;
              if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = bus.imem_rdata;
                skid_pc_d    = inflight_pc_q;
              end else begin
                skid_valid_d = 1'b0;
              end
            end else if (inflight_q) begin
              out_valid_d = 1'b1;
              out_instr_d = bus.imem_rdata;
              out_pc_d    = inflight_pc_q;
            end else begin
              out_valid_d = 1'b0;
              out_instr_d = NOP_INSTR;
            end
          end else if (inflight_q) begin
            if (out_valid_q) begin
              skid_valid_d = 1'b1;
              skid_instr_d = bus.imem_rdata;
              skid_pc_d    = inflight_pc_q;
            end else begin
              out_valid_d = 1'b1;
              out_instr_d = bus.imem_rdata;
              out_pc_d    = inflight_pc_q;
            end
          end else begin
            out_valid_d = out_valid_q;
          end
        end
      end

      ST_HALT: begin
        state_d      = ST_HALT;
        out_valid_d  = 1'b0;
        out_instr_d  = NOP_INSTR;
        skid_valid_d = 1'b0;
        inflight_d   = 1'b0;
        fault_d      = 1'b1;
      end

      default: begin
        // Unreachable encoding: fail safe into the halted, flushed state
        state_d      = ST_HALT;
        out_valid_d  = 1'b0;
        out_instr_d  = NOP_INSTR;
        skid_valid_d = 1'b0;
        inflight_d   = 1'b0;
        fault_d      = 1'b1;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_fetch_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      out_valid_q   <= 1'b0;
      out_instr_q   <= NOP_INSTR;
      out_pc_q      <= 32'h0000_0000;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_q     <= 32'h0000_0000;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_fetch_q    <= pc_fetch_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus side pushes the program-order
// stream expected after every reset/redirect; a monitor pops and compares on
// every decode transfer. Directed checks cover latency, stall, redirect,
// fault and reset behaviour; a random phase mixes ready and redirects.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] SCRAMBLE  = 32'hA5A5A5A5;

  logic clk;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_xfer  = 0;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-cycle-latency instruction memory
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= bus.imem_addr ^ SCRAMBLE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Expected program-order stream from a start PC
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back({pc, pc ^ SCRAMBLE});
      pc = pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on transfer, stall stability, NOP when empty
  logic        prev_hold = 1'b0;
  logic [31:0] held_pc, held_instr;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(bus.valid_o), 32'd1);
        check("hold_pc", bus.pc_o, held_pc);
        check("hold_instr", bus.instr_o, held_instr);
      end
      if (!bus.valid_o) check("nop_when_empty", bus.instr_o, NOP_INSTR);
      if (bus.valid_o && bus.ready_i && !bus.redirect_i) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer_pc", bus.pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", bus.pc_o, e[63:32]);
          check("xfer_instr", bus.instr_o, e[31:0]);
        end
      end
      prev_hold  = bus.valid_o && !bus.ready_i && !bus.redirect_i;
      held_pc    = bus.pc_o;
      held_instr = bus.instr_o;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_instr"}, bus.instr_o, NOP_INSTR);
    check({tag, "_pc"}, bus.pc_o, 32'd0);
    check({tag, "_fault"}, 32'(bus.fault_o), 32'd0);
    check({tag, "_imem_en"}, 32'(bus.imem_en), 32'd0);
    check({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
  endtask

  // Stimulus
  initial begin
    logic [31:0] tgt;
    rst = 1'b0;
    bus.ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.target_i = 32'd0;
    #1 rst = 1'b1;
    step(); step();
    check_reset_values("reset");

    // Reset release and boot latency
    push_stream(RESET_PC);
    rst = 1'b0;
    #1 check("boot_imem_en", 32'(bus.imem_en), 32'd0);
    step();
    check("edge1_imem_en", 32'(bus.imem_en), 32'd1);
    check("edge1_imem_addr", bus.imem_addr, RESET_PC);
    check("edge1_valid", 32'(bus.valid_o), 32'd0);
    step();
    check("edge2_valid", 32'(bus.valid_o), 32'd0);
    step();
    check("edge3_valid", 32'(bus.valid_o), 32'd1);
    check("edge3_pc", bus.pc_o, RESET_PC);
    step();
    check("edge4_pc", bus.pc_o, RESET_PC + 32'd4);

    // Stall four cycles from BFC00004
    bus.ready_i = 1'b0;
    #1 check("stall0_imem_en", 32'(bus.imem_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_imem_en", 32'(bus.imem_en), 32'd0);
      check("stall_pc", bus.pc_o, RESET_PC + 32'd4);
    end
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Redirect while stalled with the skid full
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.redirect_i = 1'b1;
    bus.target_i = 32'hBFC00100;
    push_stream(32'hBFC00100);
    #1 check("redir_imem_en", 32'(bus.imem_en), 32'd0);
    step();
    bus.redirect_i = 1'b0;
    #1;
    check("redir_e1_valid", 32'(bus.valid_o), 32'd0);
    check("redir_e1_imem_en", 32'(bus.imem_en), 32'd1);
    check("redir_e1_imem_addr", bus.imem_addr, 32'hBFC00100);
    step();
    check("redir_e2_valid", 32'(bus.valid_o), 32'd0);
    step();
    check("redir_e3_valid", 32'(bus.valid_o), 32'd1);
    check("redir_e3_pc", bus.pc_o, 32'hBFC00100);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Two back-to-back redirects: the second wins
    bus.redirect_i = 1'b1;
    bus.target_i = 32'h00000200;
    push_stream(32'h00000200);
    step();
    bus.target_i = 32'h00000300;
    push_stream(32'h00000300);
    step();
    bus.redirect_i = 1'b0;
    #1 check("dbl_imem_addr", bus.imem_addr, 32'h00000300);
    check("dbl_valid", 32'(bus.valid_o), 32'd0);
    step(); step();
    check("dbl_pc", bus.pc_o, 32'h00000300);
    for (int i = 0; i < 4; i++) step();

    // Random ready with occasional aligned redirects
    for (int i = 0; i < 400; i++) begin
      bus.ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 4) begin
        tgt = $urandom;
        tgt[1:0] = 2'b00;
        bus.redirect_i = 1'b1;
        bus.target_i = tgt;
        push_stream(tgt);
      end else begin
        bus.redirect_i = 1'b0;
      end
      step();
    end
    bus.redirect_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Reset mid-stream with a read in flight
    rst = 1'b1;
    exp_q.delete();
    #1 check_reset_values("midrst");
    step(); step();
    push_stream(RESET_PC);
    rst = 1'b0;
    step(); step(); step();
    check("restart_pc", bus.pc_o, RESET_PC);
    check("restart_valid", 32'(bus.valid_o), 32'd1);
    for (int i = 0; i < 6; i++) step();

    // Misaligned target halts until reset
    bus.redirect_i = 1'b1;
    bus.target_i = 32'hBFC00102;
    exp_q.delete();
    step();
    check("halt_fault", 32'(bus.fault_o), 32'd1);
    check("halt_valid", 32'(bus.valid_o), 32'd0);
    check("halt_imem_en", 32'(bus.imem_en), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.ready_i = ($urandom_range(0, 1) == 1);
      bus.target_i = 32'h00000400;
      step();
      check("halted_fault", 32'(bus.fault_o), 32'd1);
      check("halted_valid", 32'(bus.valid_o), 32'd0);
      check("halted_imem_en", 32'(bus.imem_en), 32'd0);
    end
    bus.redirect_i = 1'b0;

    check("xfer_count_min", 32'(n_xfer > 100), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
